hazard_scoreboard_ctrl: RTL and testbench

//  Central hazard controller for the 5-stage MIPS pipeline (F/D/E/M/W).

---
 rtl/hazard_scoreboard_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_scoreboard_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_ctrl.sv
// Pipeline hazard controller: tracks dest/Tnew of E/M/W instructions, raises stall
// on Tuse/Tnew conflicts or busy mult/div, and selects bypass sources for D and E operands.
module hazard_scoreboard_ctrl #(
    parameter int unsigned MD_MULT_CYCLES = 5,
    parameter int unsigned MD_DIV_CYCLES  = 10,
    parameter int unsigned CNT_W          = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_a3,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       md_busy
);

    logic [4:0]       e_a3_q,   e_a3_d;
    logic [1:0]       e_tnew_q, e_tnew_d;
    logic [4:0]       e_rs_q,   e_rs_d;
    logic [4:0]       e_rt_q,   e_rt_d;
    logic [4:0]       m_a3_q,   m_a3_d;
    logic [1:0]       m_tnew_q, m_tnew_d;
    logic [4:0]       w_a3_q,   w_a3_d;
    logic [1:0]       w_tnew_q, w_tnew_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic rs_hazard;
    logic rt_hazard;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // A stage can bypass operand r only once its result exists (Tnew reached 0); $0 never matches.
    function automatic logic ready_match(input logic [4:0] r, input logic [4:0] a3,
                                         input logic [1:0] tnew);
        return (r != 5'd0) && (a3 == r) && (tnew == 2'd0);
    endfunction

    always_comb begin
        rs_hazard = (d_rs != 5'd0) &&
                    (((e_a3_q == d_rs) && (e_tnew_q > d_tuse_rs)) ||
                     ((m_a3_q == d_rs) && (m_tnew_q > d_tuse_rs)));
        rt_hazard = (d_rt != 5'd0) &&
                    (((e_a3_q == d_rt) && (e_tnew_q > d_tuse_rt)) ||
                     ((m_a3_q == d_rt) && (m_tnew_q > d_tuse_rt)));
        md_busy   = (md_cnt_q != '0);
        stall     = rs_hazard | rt_hazard | (d_md_use & md_busy);
    end

    always_comb begin
        fwd_d_rs = ready_match(d_rs, e_a3_q, e_tnew_q) ? 2'b01 :
                   ready_match(d_rs, m_a3_q, m_tnew_q) ? 2'b10 :
                   ready_match(d_rs, w_a3_q, w_tnew_q) ? 2'b11 : 2'b00;
        fwd_d_rt = ready_match(d_rt, e_a3_q, e_tnew_q) ? 2'b01 :
                   ready_match(d_rt, m_a3_q, m_tnew_q) ? 2'b10 :
                   ready_match(d_rt, w_a3_q, w_tnew_q) ? 2'b11 : 2'b00;
        fwd_e_rs = ready_match(e_rs_q, m_a3_q, m_tnew_q) ? 2'b10 :
                   ready_match(e_rs_q, w_a3_q, w_tnew_q) ? 2'b11 : 2'b00;
        fwd_e_rt = ready_match(e_rt_q, m_a3_q, m_tnew_q) ? 2'b10 :
                   ready_match(e_rt_q, w_a3_q, w_tnew_q) ? 2'b11 : 2'b00;
    end

    always_comb begin
        w_a3_d   = m_a3_q;
        w_tnew_d = sat_dec(m_tnew_q);
        m_a3_d   = e_a3_q;
        m_tnew_d = sat_dec(e_tnew_q);
        if (stall) begin
            e_a3_d   = '0;
            e_tnew_d = '0;
            e_rs_d   = '0;
            e_rt_d   = '0;
        end else begin
            e_a3_d   = d_a3;
            e_tnew_d = d_tnew;
            e_rs_d   = d_rs;
            e_rt_d   = d_rt;
        end
        // Issue is gated by stall, so a start seen while busy never reloads the counter.
        md_cnt_d = md_cnt_q;
        if (!stall && d_md_start) begin
            md_cnt_d = d_md_div ? CNT_W'(MD_DIV_CYCLES) : CNT_W'(MD_MULT_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_a3_q   <= '0;
            e_tnew_q <= '0;
            e_rs_q   <= '0;
            e_rt_q   <= '0;
            m_a3_q   <= '0;
            m_tnew_q <= '0;
            w_a3_q   <= '0;
            w_tnew_q <= '0;
            md_cnt_q <= '0;
        end else begin
            e_a3_q   <= e_a3_d;
            e_tnew_q <= e_tnew_d;
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            m_a3_q   <= m_a3_d;
            m_tnew_q <= m_tnew_d;
            w_a3_q   <= w_a3_d;
            w_tnew_q <= w_tnew_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Scenario bench for hazard_scoreboard_ctrl: per-cycle D-stage stimulus with expected
// {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy} queued and checked each cycle.
module tb_hazard_scoreboard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] d_rs = '0;
    logic [4:0] d_rt = '0;
    logic [1:0] d_tuse_rs = 2'd3;
    logic [1:0] d_tuse_rt = 2'd3;
    logic [4:0] d_a3 = '0;
    logic [1:0] d_tnew = '0;
    logic       d_md_start = 1'b0;
    logic       d_md_div = 1'b0;
    logic       d_md_use = 1'b0;
    logic       stall;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
    logic       md_busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] trs;
        logic [1:0] trt;
        logic [4:0] a3;
        logic [1:0] tnew;
        logic       ms;
        logic       md;
        logic       mu;
    } in_t;

    typedef logic [9:0] exp_t;

    exp_t exp_q[$];

    hazard_scoreboard_ctrl #(
        .MD_MULT_CYCLES(5),
        .MD_DIV_CYCLES (10),
        .CNT_W         (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_a3      (d_a3),
        .d_tnew    (d_tnew),
        .d_md_start(d_md_start),
        .d_md_div  (d_md_div),
        .d_md_use  (d_md_use),
        .stall     (stall),
        .fwd_d_rs  (fwd_d_rs),
        .fwd_d_rt  (fwd_d_rt),
        .fwd_e_rs  (fwd_e_rs),
        .fwd_e_rt  (fwd_e_rt),
        .md_busy   (md_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    function automatic in_t mk_in(input int rst, input int rs, input int rt, input int trs,
                                  input int trt, input int a3, input int tnew, input int ms,
                                  input int md, input int mu);
        in_t s;
        s.rst  = 1'(rst);
        s.rs   = 5'(rs);
        s.rt   = 5'(rt);
        s.trs  = 2'(trs);
        s.trt  = 2'(trt);
        s.a3   = 5'(a3);
        s.tnew = 2'(tnew);
        s.ms   = 1'(ms);
        s.md   = 1'(md);
        s.mu   = 1'(mu);
        return s;
    endfunction

    function automatic exp_t mk_exp(input int st, input int drs, input int drt, input int ers,
                                    input int ert, input int busy);
        return {1'(st), 2'(drs), 2'(drt), 2'(ers), 2'(ert), 1'(busy)};
    endfunction

    function automatic exp_t outs();
        return {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy};
    endfunction

    function automatic in_t nop();
        return mk_in(0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
    endfunction

    task automatic drive(input in_t s);
        reset      = s.rst;
        d_rs       = s.rs;
        d_rt       = s.rt;
        d_tuse_rs  = s.trs;
        d_tuse_rt  = s.trt;
        d_a3       = s.a3;
        d_tnew     = s.tnew;
        d_md_start = s.ms;
        d_md_div   = s.md;
        d_md_use   = s.mu;
    endtask

    // Leaves the bench at a falling edge right after a reset edge.
    task automatic do_reset();
        drive(mk_in(1, 0, 0, 3, 3, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_t  st[$];
        exp_t ex[$];
        exp_t got, want;
        drive(mk_in(0, 0, 0, 3, 3, 1, 2, 1, 1, 1));
        @(negedge clk);
        drive(mk_in(0, 0, 0, 3, 3, 2, 1, 0, 0, 0));
        @(negedge clk);
        do_reset();
        st.push_back(mk_in(0, 1, 2, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        st.push_back(nop());                               ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        foreach (st[k]) begin
            drive(st[k]);
            exp_q.push_back(ex[k]);
            #1;
            got  = outs();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset step %0d: got=%b want=%b", k, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_use();
        in_t  st[$];
        exp_t ex[$];
        exp_t got, want;
        do_reset();
        st.push_back(mk_in(0, 3, 0, 1, 3, 1, 2, 0, 0, 0)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        st.push_back(mk_in(0, 1, 0, 1, 3, 4, 1, 0, 0, 0)); ex.push_back(mk_exp(1, 0, 0, 0, 0, 0));
        st.push_back(mk_in(0, 1, 0, 1, 3, 4, 1, 0, 0, 0)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        st.push_back(nop());                               ex.push_back(mk_exp(0, 0, 0, 3, 0, 0));
        st.push_back(nop());                               ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        foreach (st[k]) begin
            drive(st[k]);
            exp_q.push_back(ex[k]);
            #1;
            got  = outs();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL load_use step %0d: got=%b want=%b", k, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_branch();
        in_t  st[$];
        exp_t ex[$];
        exp_t got, want;
        do_reset();
        st.push_back(mk_in(0, 0, 0, 3, 3, 1, 2, 0, 0, 0)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        st.push_back(mk_in(0, 1, 2, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(mk_exp(1, 0, 0, 0, 0, 0));
        st.push_back(mk_in(0, 1, 2, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(mk_exp(1, 0, 0, 0, 0, 0));
        st.push_back(mk_in(0, 1, 2, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(mk_exp(0, 3, 0, 0, 0, 0));
        st.push_back(nop());                               ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        foreach (st[k]) begin
            drive(st[k]);
            exp_q.push_back(ex[k]);
            #1;
            got  = outs();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL load_branch step %0d: got=%b want=%b", k, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu_branch();
        in_t  st[$];
        exp_t ex[$];
        exp_t got, want;
        do_reset();
        st.push_back(mk_in(0, 0, 0, 3, 3, 2, 1, 0, 0, 0)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        st.push_back(mk_in(0, 5, 2, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(mk_exp(1, 0, 0, 0, 0, 0));
        st.push_back(mk_in(0, 5, 2, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(mk_exp(0, 0, 2, 0, 0, 0));
        st.push_back(nop());                               ex.push_back(mk_exp(0, 0, 0, 0, 3, 0));
        foreach (st[k]) begin
            drive(st[k]);
            exp_q.push_back(ex[k]);
            #1;
            got  = outs();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL alu_branch step %0d: got=%b want=%b", k, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jal_jr();
        in_t  st[$];
        exp_t ex[$];
        exp_t got, want;
        do_reset();
        st.push_back(mk_in(0, 0, 0, 3, 3, 31, 0, 0, 0, 0)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        st.push_back(mk_in(0, 31, 0, 0, 3, 0, 0, 0, 0, 0)); ex.push_back(mk_exp(0, 1, 0, 0, 0, 0));
        st.push_back(mk_in(0, 31, 0, 0, 3, 0, 0, 0, 0, 0)); ex.push_back(mk_exp(0, 2, 0, 2, 0, 0));
        st.push_back(mk_in(0, 31, 0, 0, 3, 0, 0, 0, 0, 0)); ex.push_back(mk_exp(0, 3, 0, 3, 0, 0));
        st.push_back(nop());                                ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        foreach (st[k]) begin
            drive(st[k]);
            exp_q.push_back(ex[k]);
            #1;
            got  = outs();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL jal_jr step %0d: got=%b want=%b", k, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fwd_priority();
        in_t  st[$];
        exp_t ex[$];
        exp_t got, want;
        do_reset();
        st.push_back(mk_in(0, 0, 0, 3, 3, 7, 0, 0, 0, 0)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        st.push_back(mk_in(0, 0, 0, 3, 3, 7, 0, 0, 0, 0)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        st.push_back(mk_in(0, 7, 7, 1, 1, 0, 0, 0, 0, 0)); ex.push_back(mk_exp(0, 1, 1, 0, 0, 0));
        st.push_back(nop());                               ex.push_back(mk_exp(0, 0, 0, 2, 2, 0));
        foreach (st[k]) begin
            drive(st[k]);
            exp_q.push_back(ex[k]);
            #1;
            got  = outs();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL fwd_priority step %0d: got=%b want=%b", k, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_reg();
        in_t  st[$];
        exp_t ex[$];
        exp_t got, want;
        do_reset();
        st.push_back(mk_in(0, 0, 0, 3, 3, 0, 2, 0, 0, 0)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        st.push_back(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        st.push_back(mk_in(0, 0, 0, 3, 3, 9, 2, 0, 0, 0)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        st.push_back(mk_in(0, 9, 9, 3, 2, 0, 0, 0, 0, 0)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        foreach (st[k]) begin
            drive(st[k]);
            exp_q.push_back(ex[k]);
            #1;
            got  = outs();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL zero_reg step %0d: got=%b want=%b", k, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_md();
        in_t  st[$];
        exp_t ex[$];
        exp_t got, want;
        do_reset();
        st.push_back(mk_in(0, 0, 0, 3, 3, 0, 0, 1, 0, 1)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            st.push_back(mk_in(0, 0, 0, 3, 3, 0, 0, 1, 0, 1)); ex.push_back(mk_exp(1, 0, 0, 0, 0, 1));
        end
        for (int i = 0; i < 3; i++) begin
            st.push_back(mk_in(0, 0, 0, 3, 3, 8, 1, 0, 0, 1)); ex.push_back(mk_exp(1, 0, 0, 0, 0, 1));
        end
        st.push_back(mk_in(0, 0, 0, 3, 3, 8, 1, 0, 0, 1)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        st.push_back(mk_in(0, 0, 0, 3, 3, 0, 0, 1, 1, 1)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        st.push_back(mk_in(0, 0, 0, 3, 3, 4, 1, 0, 0, 0)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 9; i++) begin
            st.push_back(mk_in(0, 0, 0, 3, 3, 8, 1, 0, 0, 1)); ex.push_back(mk_exp(1, 0, 0, 0, 0, 1));
        end
        st.push_back(mk_in(0, 0, 0, 3, 3, 8, 1, 0, 0, 1)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        foreach (st[k]) begin
            drive(st[k]);
            exp_q.push_back(ex[k]);
            #1;
            got  = outs();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL md step %0d: got=%b want=%b", k, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_stall();
        in_t  st[$];
        exp_t ex[$];
        exp_t got, want;
        do_reset();
        st.push_back(mk_in(0, 0, 0, 3, 3, 0, 0, 1, 1, 1)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        st.push_back(mk_in(0, 0, 0, 3, 3, 1, 2, 0, 0, 0)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 1));
        st.push_back(mk_in(0, 1, 0, 0, 3, 0, 0, 0, 0, 1)); ex.push_back(mk_exp(1, 0, 0, 0, 0, 1));
        st.push_back(mk_in(1, 1, 0, 0, 3, 0, 0, 0, 0, 1)); ex.push_back(mk_exp(1, 0, 0, 0, 0, 1));
        st.push_back(mk_in(0, 1, 0, 0, 3, 0, 0, 0, 0, 1)); ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        st.push_back(nop());                               ex.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        foreach (st[k]) begin
            drive(st[k]);
            exp_q.push_back(ex[k]);
            #1;
            got  = outs();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_mid_stall step %0d: got=%b want=%b", k, got, want);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_use();
        test_load_branch();
        test_alu_branch();
        test_jal_jr();
        test_fwd_priority();
        test_zero_reg();
        test_md();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
